// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
package sdram_arb_pkg;

  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned ARB_ADDR_W = 23;
  localparam int unsigned WADDR_W    = ARB_ADDR_W - 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT_LO = 3'd1;
  localparam logic [2:0] ST_CAP_LO  = 3'd2;
  localparam logic [2:0] ST_WAIT_HI = 3'd3;
  localparam logic [2:0] ST_CAP_HI  = 3'd4;

  typedef enum logic [2:0] {
    ARB_IDLE    = ST_IDLE,
    ARB_WAIT_LO = ST_WAIT_LO,
    ARB_CAP_LO  = ST_CAP_LO,
    ARB_WAIT_HI = ST_WAIT_HI,
    ARB_CAP_HI  = ST_CAP_HI
  } arb_state_e;

  // Latched request; addr holds the 32-bit word address (byte lanes dropped).
  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic [31:0]        wdata;
    logic [3:0]         wstrb;
    logic               id;
  } req_t;

  // Byte enables for one 16-bit half; reads always fetch both bytes.
  function automatic logic [1:0] half_ds(input logic [3:0] wstrb, input logic hi);
    logic [1:0] ds;
    ds = hi ? wstrb[3:2] : wstrb[1:0];
    if (wstrb == 4'b0000) ds = 2'b11;
    return ds;
  endfunction

endpackage

// File: rtl/sdram_half_xfer.sv
// Toggle-handshake engine for one 16-bit SDRAM transaction at a time.
// Optional ack watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_half_xfer
  import sdram_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic wait_i,
  input  logic sd_req_ack_i,
  output logic sd_req_o,
  output logic done_c,
  output logic timeout_c,
  output logic timeout_err_o
);

  if (TIMEOUT_CYCLES < 2) begin : g_cfg_err
    $error("sdram_half_xfer: TIMEOUT_CYCLES must be at least 2");
  end

  logic req_q;
  logic match_c;

  assign match_c  = (req_q == sd_req_ack_i);
  assign done_c   = wait_i & match_c;
  assign sd_req_o = req_q;

  // Request toggle; reset and watchdog expiry resync to the ack so no request is left pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= sd_req_ack_i;
    end else if (start_i) begin
      req_q <= ~req_q;
    end else if (timeout_c) begin
      req_q <= sd_req_ack_i;
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign timeout_c     = wait_i & ~match_c & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err_o = err_q;

  // Wait-cycle counter restarted on every toggle; sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (start_i) begin
        cnt_q <= '0;
      end else if (wait_i && !match_c) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (timeout_c) err_q <= 1'b1;
    end
  end
`else
  assign timeout_c     = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the 16-bit toggle-handshake SDRAM channel between
// two 32-bit valid/ready requesters; each access is split into lo/hi halves.
// Build option: SDRAM_ARB_TIMEOUT_EN adds an ack watchdog with sticky timeout_err.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 23,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic              sd_req,
  input  logic              sd_req_ack,
  output logic [ADDR_W-2:0] sd_addr,
  output logic              sd_we,
  output logic [1:0]        sd_ds,
  output logic [15:0]       sd_din,
  input  logic [15:0]       sd_dout,
  output logic              busy,
  output logic              timeout_err
);

  if (ADDR_W != ARB_ADDR_W) begin : g_cfg_err
    $error("sdram_port_arbiter: ADDR_W must match ARB_ADDR_W in sdram_arb_pkg");
  end

  arb_state_e          state_q, state_d;
  req_t                req_q, req_d;
  logic                rr_last_q, rr_last_d;
  logic [NUM_REQ-1:0]  ready_q, ready_d;
  logic [31:0]         rdata_q [NUM_REQ];
  logic [31:0]         rdata_d [NUM_REQ];
  logic [ADDR_W-2:0]   sd_addr_q, sd_addr_d;
  logic                sd_we_q, sd_we_d;
  logic [1:0]          sd_ds_q, sd_ds_d;
  logic [15:0]         sd_din_q, sd_din_d;
  logic                busy_q;

  logic                gnt_c;
  logic                gnt_id_c;
  req_t                sel_req_c;
  req_t                cur_c;
  logic                load_c;
  logic                hi_c;
  logic                wait_c;
  logic                done_c;
  logic                timeout_c;
  logic                unused_addr_lsbs;

  assign unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

  // No grant while a ready pulse is out: the finishing requester still shows valid that cycle.
  assign gnt_c    = (m0_valid | m1_valid) & (ready_q == '0);
  assign gnt_id_c = m1_valid & (~m0_valid | ~rr_last_q);
  assign wait_c   = (state_q == ARB_WAIT_LO) | (state_q == ARB_WAIT_HI);

  // Mux the winning requester's fields.
  always_comb begin
    sel_req_c       = '0;
    sel_req_c.id    = gnt_id_c;
    sel_req_c.addr  = gnt_id_c ? m1_addr[ADDR_W-1:2] : m0_addr[ADDR_W-1:2];
    sel_req_c.wdata = gnt_id_c ? m1_wdata : m0_wdata;
    sel_req_c.wstrb = gnt_id_c ? m1_wstrb : m0_wstrb;
  end

  sdram_half_xfer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_half_xfer (
    .clk           (clk),
    .reset         (reset),
    .start_i       (load_c),
    .wait_i        (wait_c),
    .sd_req_ack_i  (sd_req_ack),
    .sd_req_o      (sd_req),
    .done_c        (done_c),
    .timeout_c     (timeout_c),
    .timeout_err_o (timeout_err)
  );

  // Access sequencer: next state, half-word setup and ready/rdata updates.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rr_last_d = rr_last_q;
    ready_d   = '0;
    rdata_d   = rdata_q;
    sd_addr_d = sd_addr_q;
    sd_we_d   = sd_we_q;
    sd_ds_d   = sd_ds_q;
    sd_din_d  = sd_din_q;
    cur_c     = req_q;
    load_c    = 1'b0;
    hi_c      = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (gnt_c) begin
          cur_c     = sel_req_c;
          req_d     = sel_req_c;
          rr_last_d = gnt_id_c;
          load_c    = 1'b1;
          if ((sel_req_c.wstrb != 4'b0000) && (sel_req_c.wstrb[1:0] == 2'b00)) begin
            hi_c    = 1'b1;
            state_d = ARB_WAIT_HI;
          end else begin
            state_d = ARB_WAIT_LO;
          end
        end
      end
      ARB_WAIT_LO: begin
        if (timeout_c) begin
          ready_d[req_q.id] = 1'b1;
          rdata_d[req_q.id] = '0;
          state_d           = ARB_IDLE;
        end else if (done_c) begin
          if (req_q.wstrb == 4'b0000) begin
            state_d = ARB_CAP_LO;
          end else if (req_q.wstrb[3:2] == 2'b00) begin
            ready_d[req_q.id] = 1'b1;
            state_d           = ARB_IDLE;
          end else begin
            load_c  = 1'b1;
            hi_c    = 1'b1;
            state_d = ARB_WAIT_HI;
          end
        end
      end
      ARB_CAP_LO: begin
        rdata_d[req_q.id][15:0] = sd_dout;
        load_c                  = 1'b1;
        hi_c                    = 1'b1;
        state_d                 = ARB_WAIT_HI;
      end
      ARB_WAIT_HI: begin
        if (timeout_c) begin
          ready_d[req_q.id] = 1'b1;
          rdata_d[req_q.id] = '0;
          state_d           = ARB_IDLE;
        end else if (done_c) begin
          if (req_q.wstrb != 4'b0000) begin
            ready_d[req_q.id] = 1'b1;
            state_d           = ARB_IDLE;
          end else begin
            state_d = ARB_CAP_HI;
          end
        end
      end
      ARB_CAP_HI: begin
        rdata_d[req_q.id][31:16] = sd_dout;
        ready_d[req_q.id]        = 1'b1;
        state_d                  = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if (load_c) begin
      sd_addr_d = {cur_c.addr, hi_c};
      sd_we_d   = (cur_c.wstrb != 4'b0000);
      sd_ds_d   = half_ds(cur_c.wstrb, hi_c);
      sd_din_d  = hi_c ? cur_c.wdata[31:16] : cur_c.wdata[15:0];
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      req_q     <= '0;
      rr_last_q <= 1'b1;
      ready_q   <= '0;
      for (int i = 0; i < int'(NUM_REQ); i++) rdata_q[i] <= '0;
      sd_addr_q <= '0;
      sd_we_q   <= 1'b0;
      sd_ds_q   <= 2'b00;
      sd_din_q  <= 16'h0000;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rr_last_q <= rr_last_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      sd_addr_q <= sd_addr_d;
      sd_we_q   <= sd_we_d;
      sd_ds_q   <= sd_ds_d;
      sd_din_q  <= sd_din_d;
      busy_q    <= (state_d != ARB_IDLE);
    end
  end

  assign m0_ready = ready_q[0];
  assign m1_ready = ready_q[1];
  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];
  assign sd_addr  = sd_addr_q;
  assign sd_we    = sd_we_q;
  assign sd_ds    = sd_ds_q;
  assign sd_din   = sd_din_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: SDRAM responder model with programmable ack delay,
// scoreboard of expected completions checked on every ready pulse.
module tb_sdram_port_arbiter;

  localparam int unsigned ADDR_W = 23;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        m_valid = 2'b00;
  logic [ADDR_W-1:0] m_addr  [2];
  logic [31:0]       m_wdata [2];
  logic [3:0]        m_wstrb [2];
  logic              m0_ready, m1_ready;
  logic [31:0]       m0_rdata, m1_rdata;
  logic              sd_req;
  logic              sd_req_ack = 1'b1;
  logic [ADDR_W-2:0] sd_addr;
  logic              sd_we;
  logic [1:0]        sd_ds;
  logic [15:0]       sd_din;
  logic [15:0]       sd_dout = 16'h0000;
  logic              busy;
  logic              timeout_err;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m_valid[0]), .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m_valid[1]), .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .sd_req(sd_req), .sd_req_ack(sd_req_ack), .sd_addr(sd_addr), .sd_we(sd_we),
    .sd_ds(sd_ds), .sd_din(sd_din), .sd_dout(sd_dout),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    bit          chk;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          toggles = 0;
  logic        prev_req = 1'b0;
  int          ack_dly = 1;
  bit          ack_en  = 1'b1;
  int          ack_cnt = 0;
  logic [15:0] mem [logic [21:0]];
  logic [21:0] last_addr = '0;
  logic [1:0]  last_ds = '0;
  logic [15:0] last_din = '0;
  logic        last_we = 1'b0;
  logic [15:0] wtmp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [21:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // SDRAM responder: completes a pending toggle after ack_dly cycles.
  always @(negedge clk) begin
    if (sd_req !== prev_req) begin
      toggles++;
      prev_req = sd_req;
    end
    if (!reset && ack_en && (sd_req != sd_req_ack)) begin
      ack_cnt++;
      if (ack_cnt >= ack_dly) begin
        ack_cnt = 0;
        if (sd_we) begin
          wtmp = mem_rd(sd_addr);
          if (sd_ds[0]) wtmp[7:0]  = sd_din[7:0];
          if (sd_ds[1]) wtmp[15:8] = sd_din[15:8];
          mem[sd_addr] = wtmp;
        end else begin
          sd_dout = mem_rd(sd_addr);
        end
        last_addr  = sd_addr;
        last_ds    = sd_ds;
        last_din   = sd_din;
        last_we    = sd_we;
        sd_req_ack = sd_req;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  // Scoreboard: every ready pulse must match the next expected completion.
  always @(negedge clk) begin
    if (!reset && (m0_ready || m1_ready)) begin
      check("one_ready", 32'(m0_ready & m1_ready), 32'd0);
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("ready_port", 32'(m1_ready), 32'(mon_e.id));
        if (mon_e.chk) check("rdata", m1_ready ? m1_rdata : m0_rdata, mon_e.rdata);
      end
    end
  end

  task automatic expect_done(input int id, input logic [31:0] rd, input bit chk);
    exp_t e;
    e.id = id; e.rdata = rd; e.chk = chk;
    sb_q.push_back(e);
  endtask

  // Present a request and hold it until its ready pulse; valid stays high for the caller.
  task automatic port_req(input int id, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, output int lat);
    int t0;
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    m_valid[id] = 1'b1;
    m_addr[id]  = addr;
    m_wdata[id] = wd;
    m_wstrb[id] = st;
    t0 = cyc;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if ((id == 0) ? m0_ready : m1_ready) begin
        got = 1'b1;
        break;
      end
    end
    check($sformatf("ready_seen_m%0d", id), 32'(got), 32'd1);
    lat = cyc - t0;
  endtask

  task automatic port_drop(input int id);
    @(posedge clk); #1;
    m_valid[id] = 1'b0;
  endtask

  initial begin
    int lat;
    int tog0;
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0; m_wdata[i] = '0; m_wstrb[i] = '0;
    end
    mem[22'h33000] = 16'h1234;
    mem[22'h33001] = 16'hABCD;

    // Reset values, and sd_req resynchronised to a high ack.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_m0_ready", 32'(m0_ready), 32'd0);
    check("rst_m1_ready", 32'(m1_ready), 32'd0);
    check("rst_m0_rdata", m0_rdata, 32'h0);
    check("rst_m1_rdata", m1_rdata, 32'h0);
    check("rst_sd_we", 32'(sd_we), 32'd0);
    check("rst_sd_ds", 32'(sd_ds), 32'd0);
    check("rst_sd_din", 32'(sd_din), 32'd0);
    check("rst_sd_addr", 32'(sd_addr), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_req_sync", 32'(sd_req), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // m0 read, ack after 3 cycles.
    ack_dly = 3;
    tog0 = toggles;
    expect_done(0, 32'hABCD1234, 1'b1);
    port_req(0, 23'h66000, 32'h0, 4'b0000, lat);
    check("rd_lat_d3", 32'(lat), 32'd9);
    check("rd_toggles", 32'(toggles - tog0), 32'd2);
    port_drop(0);

    // m1 upper-half write: only the hi transaction.
    tog0 = toggles;
    expect_done(1, 32'h0, 1'b0);
    port_req(1, 23'h66004, 32'h5555AAAA, 4'b1100, lat);
    check("whi_lat_d3", 32'(lat), 32'd4);
    check("whi_toggles", 32'(toggles - tog0), 32'd1);
    check("whi_addr", 32'(last_addr), 32'h33003);
    check("whi_ds", 32'(last_ds), 32'd3);
    check("whi_din", 32'(last_din), 32'h5555);
    check("whi_we", 32'(last_we), 32'd1);
    port_drop(1);

    // m0 lower-half write: ready after the first match.
    tog0 = toggles;
    expect_done(0, 32'h0, 1'b0);
    port_req(0, 23'h66008, 32'h0000BEEF, 4'b0011, lat);
    check("wlo_lat_d3", 32'(lat), 32'd4);
    check("wlo_toggles", 32'(toggles - tog0), 32'd1);
    check("wlo_addr", 32'(last_addr), 32'h33004);
    check("wlo_ds", 32'(last_ds), 32'd3);
    check("wlo_din", 32'(last_din), 32'hBEEF);
    port_drop(0);

    // Minimum latencies with an immediate ack.
    ack_dly = 1;
    expect_done(1, 32'hABCD1234, 1'b1);
    port_req(1, 23'h66000, 32'h0, 4'b0000, lat);
    check("rd_lat_d1", 32'(lat), 32'd5);
    port_drop(1);
    tog0 = toggles;
    expect_done(0, 32'h0, 1'b0);
    port_req(0, 23'h6600C, 32'hCAFEF00D, 4'b1111, lat);
    check("wfull_lat_d1", 32'(lat), 32'd3);
    check("wfull_toggles", 32'(toggles - tog0), 32'd2);
    port_drop(0);
    expect_done(0, 32'hCAFEF00D, 1'b1);
    port_req(0, 23'h6600C, 32'h0, 4'b0000, lat);
    port_drop(0);
    expect_done(1, 32'h0, 1'b0);
    port_req(1, 23'h66000, 32'h00770000, 4'b0100, lat);
    check("wbyte_lat_d1", 32'(lat), 32'd2);
    check("wbyte_ds", 32'(last_ds), 32'd1);
    check("wbyte_din", 32'(last_din), 32'h0077);
    check("wbyte_addr", 32'(last_addr), 32'h33001);
    port_drop(1);

    // Both ports busy: grants alternate starting with m0.
    expect_done(0, 32'hAB771234, 1'b1);
    expect_done(1, 32'h55550000, 1'b1);
    expect_done(0, 32'hCAFEF00D, 1'b1);
    expect_done(1, 32'h0000BEEF, 1'b1);
    fork
      begin
        int l0;
        port_req(0, 23'h66000, 32'h0, 4'b0000, l0);
        port_req(0, 23'h6600C, 32'h0, 4'b0000, l0);
        port_drop(0);
      end
      begin
        int l1;
        port_req(1, 23'h66004, 32'h0, 4'b0000, l1);
        port_req(1, 23'h66008, 32'h0, 4'b0000, l1);
        port_drop(1);
      end
    join

    // Reset while WAIT_HI has an outstanding ack: access dropped, no ready.
    ack_dly = 3;
    @(posedge clk); #1;
    m_valid[0] = 1'b1; m_addr[0] = 23'h66000; m_wdata[0] = 32'h0; m_wstrb[0] = 4'b0000;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_pending", 32'(sd_req != sd_req_ack), 32'd1);
    reset = 1'b1;
    m_valid[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_req_sync", 32'(sd_req == sd_req_ack), 32'd1);
    check("mid_rst_no_ready", 32'(m0_ready | m1_ready), 32'd0);
    repeat (6) @(negedge clk);

`ifdef SDRAM_ARB_TIMEOUT_EN
    // Ack never returns: watchdog completes the read with zero data.
    ack_en = 1'b0;
    expect_done(0, 32'h0, 1'b1);
    port_req(0, 23'h66000, 32'h0, 4'b0000, lat);
    check("to_lat", 32'(lat), 32'd17);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_req_sync", 32'(sd_req == sd_req_ack), 32'd1);
    port_drop(0);
    ack_en = 1'b1;
`else
    check("timeout_err_off", 32'(timeout_err), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
